mem_write_checker: RTL and testbench
====================================

MEM_WRITE_CHECKER -- requirements
Module: mem_write_checker

Interface
REQ-001 Parameter AW, 32, address width.
REQ-002 Parameter DW, 32, data width.
REQ-003 Parameter DEPTH, 4, max expected-write entries (power of two, >=2); IW = clog2(DEPTH), NW = clog2(DEPTH+1).
REQ-004 Parameter IGN_ADR, 80, tolerated scratch address; writes to it are ignored.
REQ-005 Parameter CW, 32, cycle counter width.
REQ-006 Parameter TIMEOUT, 1000, RUN-cycle limit.
REQ-007 clk  in  1  single clock, all state changes on rising edge.
REQ-008 reset  in  1  synchronous, active-high.
REQ-009 memwrite  in  1  processor store strobe.
REQ-010 dataadr  in  AW  store address.
REQ-011 writedata  in  DW  store data.
REQ-012 ld_en  in  1  write expected entry (IDLE only); ld_idx in IW, ld_adr in AW, ld_data in DW.
REQ-013 arm  in  1  start checking; n_exp in NW = number of entries to match.
REQ-014 clr  in  1  return from PASS/FAIL/TIMEOUT to IDLE, table retained.
REQ-015 busy, pass, fail, timeout  out  1 each  state flags.
REQ-016 match_cnt  out  NW  entries matched; cycle  out  CW  RUN cycles elapsed.
REQ-017 fail_adr  out  AW, fail_data  out  DW  offending store captured on FAIL.

Function
REQ-018 States IDLE, RUN, PASS, FAIL, TOUT; busy=RUN, pass=PASS, fail=FAIL, timeout=TOUT, all registered.
REQ-019 IDLE: ld_en writes table[ld_idx]; ld_en outside IDLE ignored.
REQ-020 IDLE: arm with 1<=n_exp<=DEPTH -> RUN next cycle, ptr=0, match_cnt=0, cycle=0; other n_exp values ignored, stay IDLE.
REQ-021 RUN: memwrite sampled each rising edge; one evaluation per asserted cycle (multi-cycle strobe counts once per cycle).
REQ-022 Match: dataadr==table[ptr].adr AND writedata==table[ptr].data -> ptr++, match_cnt++; if match_cnt reaches n_exp -> PASS next cycle.
REQ-023 Else dataadr==IGN_ADR -> no change; expected-match check has priority when table address equals IGN_ADR.
REQ-024 Else (any other store, incl. right address wrong data) -> FAIL, capture fail_adr/fail_data same edge.
REQ-025 RUN: cycle increments every cycle, saturates at all-ones.
REQ-026 PASS/FAIL/TOUT sticky; clr -> IDLE, flags clear, match_cnt/cycle/fail_* hold until next arm.
REQ-027 arm while not IDLE ignored; clr in IDLE/RUN ignored.
REQ-028 Only one terminal state per run; terminal outputs never glitch between states.

Reset
REQ-029 reset -> IDLE; busy/pass/fail/timeout=0, match_cnt=0, cycle=0, fail_adr=0, fail_data=0, ptr=0.
REQ-030 reset mid-RUN aborts run same edge; table contents undefined after reset, must be reloaded.
REQ-031 reset has priority over ld_en, arm, clr, memwrite.

Configuration
REQ-032 Macro MEM_WRITE_CHECKER_TIMEOUT_EN.
REQ-033 Defined: RUN with cycle==TIMEOUT-1 and no completing match -> TOUT next cycle; a completing match or failing store that same cycle wins over timeout.
REQ-034 Undefined: no TOUT state, timeout tied 0, run unbounded; cycle still counts.

Verification
REQ-035 DEPTH=4, table[0]=(84,7), n_exp=1, stores (80,x),(80,y),(84,7) -> pass=1 cycle after third store, match_cnt=1, fail=0.
REQ-036 table[0]=(84,7), store (84,6) -> fail=1, fail_adr=84, fail_data=6; store (88,7) on fresh run -> fail_adr=88.
REQ-037 table=(4,1),(8,2),(12,3), n_exp=3, in-order stores with IGN_ADR stores interleaved -> pass, match_cnt=3; out-of-order (8,2) first -> fail.
REQ-038 With MEM_WRITE_CHECKER_TIMEOUT_EN, TIMEOUT=20, no stores -> timeout=1 after cycle 19; completing match on cycle 19 -> pass, not timeout.
REQ-039 reset asserted mid-RUN after 1 of 3 matches -> all outputs zero next edge; ld_en during RUN leaves table unchanged (verified on next run); arm n_exp=0 or 5 stays IDLE.

Source files
------------

// File: rtl/mem_write_checker_if.sv
// mem_write_checker_if
// Processor store bus observed by the write checker.
//   memwrite  : store strobe, one evaluation per asserted cycle
//   dataadr   : store address (AW bits)
//   writedata : store data (DW bits)
// master drives the bus (processor or bench), slave observes it (checker).
interface mem_write_checker_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          memwrite;
  logic [AW-1:0] dataadr;
  logic [DW-1:0] writedata;

  modport master (output memwrite, dataadr, writedata);
  modport slave  (input  memwrite, dataadr, writedata);
endinterface

// File: rtl/mem_write_checker.sv
// mem_write_checker
// Watches processor stores and checks them, in order, against a small table
// of expected (address, data) writes. Stores to IGN_ADR are tolerated unless
// they are the next expected entry.
//
// Optional feature: define MEM_WRITE_CHECKER_TIMEOUT_EN to bound a run to
// TIMEOUT cycles (TOUT state, timeout flag). Without it the run is unbounded
// and timeout stays 0.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   wr                    : store bus (memwrite, dataadr, writedata)
//   ld_en/ld_idx/ld_adr/ld_data : table load, honoured in IDLE only
//   arm/n_exp             : start a run expecting n_exp entries (1..DEPTH)
//   clr                   : leave PASS/FAIL/TOUT back to IDLE, table kept
//   busy/pass/fail/timeout: registered state flags
//   match_cnt, cycle      : entries matched, RUN cycles elapsed (saturating)
//   fail_adr, fail_data   : offending store captured on the move to FAIL
//
// state  | meaning
// -------+-----------------------------------------------------------
// s_idle | waiting; table loads and arm accepted
// s_run  | checking stores against table[ptr]
// s_pass | all n_exp entries matched in order (sticky until clr)
// s_fail | unexpected store seen, captured in fail_* (sticky)
// s_tout | TIMEOUT cycles passed without completing (sticky)
module mem_write_checker #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int DEPTH   = 4,
  parameter int IGN_ADR = 80,
  parameter int CW      = 32,
  parameter int TIMEOUT = 1000,
  localparam int IW     = $clog2(DEPTH),
  localparam int NW     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_write_checker_if.slave    wr,
  input  logic                  ld_en,
  input  logic [IW-1:0]         ld_idx,
  input  logic [AW-1:0]         ld_adr,
  input  logic [DW-1:0]         ld_data,
  input  logic                  arm,
  input  logic [NW-1:0]         n_exp,
  input  logic                  clr,
  output logic                  busy,
  output logic                  pass,
  output logic                  fail,
  output logic                  timeout,
  output logic [NW-1:0]         match_cnt,
  output logic [CW-1:0]         cycle,
  output logic [AW-1:0]         fail_adr,
  output logic [DW-1:0]         fail_data
);

`ifdef MEM_WRITE_CHECKER_TIMEOUT_EN
  localparam bit TOUT_EN = 1'b1;
`else
  // s_tout is unreachable in this build, so timeout never rises.
  localparam bit TOUT_EN = 1'b0;
`endif

  localparam logic [AW-1:0] IGN     = AW'(IGN_ADR);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {s_idle, s_run, s_pass, s_fail, s_tout} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [NW-1:0] n_exp_q;

  logic [AW-1:0] tbl_adr  [DEPTH];
  logic [DW-1:0] tbl_data [DEPTH];

  logic hit, bad, last;

  // The expected-entry compare is evaluated first so that a table entry
  // sitting on IGN_ADR is still treated as a real match.
  assign hit  = wr.memwrite && (wr.dataadr == tbl_adr[ptr]) &&
                (wr.writedata == tbl_data[ptr]);
  assign bad  = wr.memwrite && !hit && (wr.dataadr != IGN);
  assign last = (match_cnt + 1'b1) == n_exp_q;

  // Table has no reset: contents are meaningless after reset and get reloaded.
  always_ff @(posedge clk) begin
    if (!reset && ld_en && state == s_idle) begin
      tbl_adr[ld_idx]  <= ld_adr;
      tbl_data[ld_idx] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= s_idle;
      busy      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      timeout   <= 1'b0;
      match_cnt <= '0;
      cycle     <= '0;
      fail_adr  <= '0;
      fail_data <= '0;
      ptr       <= '0;
      n_exp_q   <= '0;
    end else begin
      case (state)
        s_idle: begin
          if (arm && n_exp != '0 && n_exp <= NW'(DEPTH)) begin
            state     <= s_run;
            busy      <= 1'b1;
            ptr       <= '0;
            match_cnt <= '0;
            cycle     <= '0;
            n_exp_q   <= n_exp;
          end
        end

        s_run: begin
          if (cycle != '1) cycle <= cycle + 1'b1;
          if (hit) begin
            ptr       <= ptr + 1'b1;
            match_cnt <= match_cnt + 1'b1;
          end
          // Completion and a bad store both outrank the timeout on the
          // same edge; a non-completing match does not.
          if (hit && last) begin
            state <= s_pass;
            busy  <= 1'b0;
            pass  <= 1'b1;
          end else if (bad) begin
            state     <= s_fail;
            busy      <= 1'b0;
            fail      <= 1'b1;
            fail_adr  <= wr.dataadr;
            fail_data <= wr.writedata;
          end else if (TOUT_EN && cycle == TO_LAST) begin
            state   <= s_tout;
            busy    <= 1'b0;
            timeout <= 1'b1;
          end
        end

        s_pass, s_fail, s_tout: begin
          if (clr) begin
            state   <= s_idle;
            pass    <= 1'b0;
            fail    <= 1'b0;
            timeout <= 1'b0;
          end
        end

        default: begin
          state   <= s_idle;
          busy    <= 1'b0;
          pass    <= 1'b0;
          fail    <= 1'b0;
          timeout <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_write_checker.sv
module tb_mem_write_checker;

  localparam int AW = 32, DW = 32, DEPTH = 4, IW = 2, NW = 3, CW = 32;
  localparam int IGN = 80;
  localparam int TMO = 20;
`ifdef MEM_WRITE_CHECKER_TIMEOUT_EN
  localparam bit TOUT_EN = 1'b1;
`else
  localparam bit TOUT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ld_en = 1'b0;
  logic [IW-1:0] ld_idx = '0;
  logic [AW-1:0] ld_adr = '0;
  logic [DW-1:0] ld_data = '0;
  logic          arm = 1'b0;
  logic [NW-1:0] n_exp = '0;
  logic          clr = 1'b0;
  logic          busy, pass, fail, timeout;
  logic [NW-1:0] match_cnt;
  logic [CW-1:0] cycle;
  logic [AW-1:0] fail_adr;
  logic [DW-1:0] fail_data;

  mem_write_checker_if #(.AW(AW), .DW(DW)) wr_if ();

  mem_write_checker #(
    .AW(AW), .DW(DW), .DEPTH(DEPTH), .IGN_ADR(IGN), .CW(CW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .wr(wr_if),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_adr(ld_adr), .ld_data(ld_data),
    .arm(arm), .n_exp(n_exp), .clr(clr),
    .busy(busy), .pass(pass), .fail(fail), .timeout(timeout),
    .match_cnt(match_cnt), .cycle(cycle),
    .fail_adr(fail_adr), .fail_data(fail_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { logic [31:0] adr; logic [31:0] data; } ent_t;
  localparam int M_IDLE = 0, M_RUN = 1, M_PASS = 2, M_BAD = 3, M_TOUT = 4;

  ent_t        m_tbl [DEPTH];
  ent_t        m_q [$];        // expected stores still outstanding, in order
  int          m_st = M_IDLE;
  int          m_mc = 0;
  logic [31:0] m_cyc = '0;
  logic [31:0] m_fa = '0, m_fd = '0;

  always @(posedge clk) begin
    logic [31:0] old;
    if (reset) begin
      m_st = M_IDLE; m_mc = 0; m_cyc = '0; m_fa = '0; m_fd = '0;
      m_q.delete();
    end else begin
      case (m_st)
        M_IDLE: begin
          if (ld_en) m_tbl[ld_idx] = '{ld_adr, ld_data};
          if (arm && n_exp >= 1 && n_exp <= DEPTH) begin
            m_st = M_RUN; m_mc = 0; m_cyc = '0;
            m_q.delete();
            for (int i = 0; i < int'(n_exp); i++) m_q.push_back(m_tbl[i]);
          end
        end
        M_RUN: begin
          old = m_cyc;
          if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
          if (wr_if.memwrite && m_q.size() > 0 && wr_if.dataadr == m_q[0].adr &&
              wr_if.writedata == m_q[0].data) begin
            void'(m_q.pop_front());
            m_mc++;
            if (m_q.size() == 0) m_st = M_PASS;
          end else if (wr_if.memwrite && wr_if.dataadr != IGN) begin
            m_st = M_BAD; m_fa = wr_if.dataadr; m_fd = wr_if.writedata;
          end
          if (m_st == M_RUN && TOUT_EN && old == TMO - 1) m_st = M_TOUT;
        end
        default: if (clr) m_st = M_IDLE;
      endcase
    end
  end

  // Single compare process: every cycle after the first reset edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("busy",      busy,      m_st == M_RUN);
      cmp("pass",      pass,      m_st == M_PASS);
      cmp("fail",      fail,      m_st == M_BAD);
      cmp("timeout",   timeout,   m_st == M_TOUT);
      cmp("match_cnt", match_cnt, m_mc);
      cmp("cycle",     cycle,     m_cyc);
      cmp("fail_adr",  fail_adr,  m_fa);
      cmp("fail_data", fail_data, m_fd);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic quiet();
    reset = 1'b0; ld_en = 1'b0; arm = 1'b0; clr = 1'b0;
    wr_if.memwrite = 1'b0;
  endtask

  task automatic load(input int idx, input int adr, input int data);
    ld_en = 1'b1; ld_idx = IW'(idx); ld_adr = AW'(adr); ld_data = DW'(data);
    nxt(); ld_en = 1'b0;
  endtask

  task automatic arm_run(input int n);
    arm = 1'b1; n_exp = NW'(n);
    nxt(); arm = 1'b0;
  endtask

  task automatic store(input int adr, input int data);
    wr_if.memwrite = 1'b1; wr_if.dataadr = AW'(adr); wr_if.writedata = DW'(data);
    nxt(); wr_if.memwrite = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1; nxt(); clr = 1'b0;
  endtask

  function automatic logic [31:0] pick_adr();
    case ($urandom_range(0, 5))
      0: return 32'd4;
      1: return 32'd8;
      2: return 32'd12;
      3: return 32'd80;
      4: return 32'd84;
      default: return 32'd88;
    endcase
  endfunction

  task automatic reload_rand();
    for (int i = 0; i < DEPTH; i++) load(i, int'(pick_adr()), int'($urandom_range(0, 3)));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    wr_if.memwrite = 1'b0; wr_if.dataadr = '0; wr_if.writedata = '0;
    reset = 1'b1;
    nxt();
    chk_en = 1'b1;
    nxt();
    quiet();
    cmp("rst_busy", busy, 0);
    cmp("rst_pass", pass, 0);
    cmp("rst_mc", match_cnt, 0);
    cmp("rst_cycle", cycle, 0);

    // single expected store with two tolerated scratch stores before it
    load(0, 84, 7);
    arm_run(1);
    store(80, 1);
    store(80, 2);
    store(84, 7);
    cmp("ign_pass", pass, 1);
    cmp("ign_mc", match_cnt, 1);
    cmp("ign_fail", fail, 0);
    cmp("ign_cycle", cycle, 3);
    do_clr();
    cmp("clr_pass", pass, 0);
    cmp("clr_mc_hold", match_cnt, 1);

    // right address, wrong data; then wrong address
    arm_run(1);
    store(84, 6);
    cmp("wd_fail", fail, 1);
    cmp("wd_adr", fail_adr, 84);
    cmp("wd_data", fail_data, 6);
    do_clr();
    arm_run(1);
    store(88, 7);
    cmp("wa_adr", fail_adr, 88);
    do_clr();

    // three entries in order with scratch stores interleaved
    load(0, 4, 1); load(1, 8, 2); load(2, 12, 3);
    arm_run(3);
    store(4, 1); store(80, 9); store(8, 2); store(80, 0); store(12, 3);
    cmp("seq_pass", pass, 1);
    cmp("seq_mc", match_cnt, 3);
    do_clr();
    arm_run(3);
    store(8, 2);
    cmp("ooo_fail", fail, 1);
    cmp("ooo_adr", fail_adr, 8);
    do_clr();

    // reset in the middle of a run
    arm_run(3);
    store(4, 1);
    cmp("mid_mc", match_cnt, 1);
    reset = 1'b1; nxt(); reset = 1'b0;
    cmp("rr_busy", busy, 0);
    cmp("rr_mc", match_cnt, 0);
    cmp("rr_cycle", cycle, 0);
    cmp("rr_fadr", fail_adr, 0);

    // table load during RUN must be ignored
    load(0, 4, 1); load(1, 8, 2); load(2, 12, 3);
    arm_run(3);
    load(1, 99, 99);
    store(4, 1); store(8, 2); store(12, 3);
    cmp("ldrun_pass", pass, 1);
    do_clr();
    arm_run(0);
    cmp("arm0_busy", busy, 0);
    arm_run(5);
    cmp("arm5_busy", busy, 0);
    arm_run(3);
    store(4, 1); store(8, 2); store(12, 3);
    cmp("retain_pass", pass, 1);
    do_clr();

`ifdef MEM_WRITE_CHECKER_TIMEOUT_EN
    arm_run(1);
    repeat (TMO - 1) nxt();
    cmp("to_pre_busy", busy, 1);
    cmp("to_pre_cyc", cycle, TMO - 1);
    nxt();
    cmp("to_flag", timeout, 1);
    cmp("to_pass", pass, 0);
    do_clr();
    arm_run(1);
    repeat (TMO - 1) nxt();
    store(4, 1);
    cmp("tolast_pass", pass, 1);
    cmp("tolast_to", timeout, 0);
    do_clr();
`else
    arm_run(1);
    repeat (30) nxt();
    cmp("unb_busy", busy, 1);
    cmp("unb_to", timeout, 0);
    cmp("unb_cycle", cycle, 30);
    store(4, 1);
    cmp("unb_pass", pass, 1);
    do_clr();
`endif

    // randomized phase
    reload_rand();
    for (int n = 0; n < 3000; n++) begin
      int r;
      reset   = ($urandom_range(0, 299) == 0);
      ld_en   = ($urandom_range(0, 3) == 0);
      ld_idx  = IW'($urandom_range(0, DEPTH - 1));
      ld_adr  = pick_adr();
      ld_data = DW'($urandom_range(0, 3));
      arm     = ($urandom_range(0, 4) == 0);
      n_exp   = NW'($urandom_range(0, 7));
      clr     = ($urandom_range(0, 5) == 0);
      wr_if.memwrite = ($urandom_range(0, 1) == 1);
      r = $urandom_range(0, 9);
      if (r < 6 && m_q.size() > 0) begin
        wr_if.dataadr = m_q[0].adr; wr_if.writedata = m_q[0].data;
      end else if (r < 8) begin
        wr_if.dataadr = IGN; wr_if.writedata = $urandom;
      end else begin
        wr_if.dataadr = pick_adr(); wr_if.writedata = DW'($urandom_range(0, 3));
      end
      nxt();
      if (reset) begin
        quiet();
        reload_rand();
      end
    end
    quiet();
    nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
